// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the set-associative data cache.
// Optional build macro: DCACHE_STATS_EN (hit/miss counters on the top).
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH,
        REFILL
    } state_t;

    function automatic int off_w(input int words);
        return $clog2(words) + 2;
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int aw, input int sets, input int words);
        return aw - off_w(words) - idx_w(sets);
    endfunction

    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/dcache_lru.sv
// Per-set LRU rank table; rank 0 is MRU, rank WAYS-1 is the victim.
// Optional build macro: none.
module dcache_lru
    import dcache_pkg::*;
#(
    parameter int SETS = 8,
    parameter int WAYS = 2,
    localparam int IW = idx_w(SETS),
    localparam int WW = way_w(WAYS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [IW-1:0] index,
    input  logic [WW-1:0] way,
    input  logic          update,
    output logic [WW-1:0] victim
);

    logic [WW-1:0] rank [SETS][WAYS];
    logic [WW-1:0] old;

    assign old = rank[index][way];

    // Ties with the old rank also age, so reset-cleared ranks become a permutation.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    rank[s][w] <= '0;
        end else if (update) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WW'(w) == way)
                    rank[index][w] <= '0;
                else if (rank[index][w] <= old)
                    rank[index][w] <= rank[index][w] + 1'b1;
            end
        end
    end

    always_comb begin
        victim = '0;
        for (int w = 0; w < WAYS; w++)
            if (rank[index][w] == WW'(WAYS - 1))
                victim = WW'(w);
    end

endmodule

// File: rtl/dcache_assoc.sv
// N-way set-associative write-back, write-allocate data cache with LRU.
// Optional build macro: DCACHE_STATS_EN adds hit_count/miss_count outputs.
module dcache_assoc
    import dcache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int SETS = 8,
    parameter int WAYS = 2,
    parameter int WORDS = 4,
    localparam int OFF = off_w(WORDS),
    localparam int MA_W = ADDR_W - OFF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_W-1:0]     address,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic                  busywait,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [MA_W-1:0]       mem_address,
    output logic [32*WORDS-1:0]   mem_writedata,
    input  logic [32*WORDS-1:0]   mem_readdata,
    input  logic                  mem_busywait
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int IDX = idx_w(SETS);
    localparam int TAG_W = tag_w(ADDR_W, SETS, WORDS);
    localparam int WW = way_w(WAYS);
    localparam int WDW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [TAG_W-1:0] tags  [SETS][WAYS];
    logic [31:0]      data  [SETS][WAYS][WORDS];
    logic [WAYS-1:0]  valid [SETS];
    logic [WAYS-1:0]  dirty [SETS];

    state_t           state;
    logic [WW-1:0]    v_way;
    logic [IDX-1:0]   r_index;
    logic [TAG_W-1:0] r_tag;

    logic [WDW-1:0]   word;
    logic [IDX-1:0]   index;
    logic [TAG_W-1:0] tag;
    logic             hit, req, miss, found;
    logic [WW-1:0]    hit_way, victim, lru_victim, lru_way;
    logic [IDX-1:0]   lru_index;
    logic             lru_update;
    logic [32*WORDS-1:0] victim_block;

    assign word  = (WORDS > 1) ? WDW'(address >> 2) : '0;
    assign index = IDX'(address >> OFF);
    assign tag   = TAG_W'(address >> (OFF + IDX));

    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[index][w] && tags[index][w] == tag) begin
                hit = 1'b1;
                hit_way = WW'(w);
            end
        end
    end

    always_comb begin
        victim = lru_victim;
        found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid[index][w]) begin
                victim = WW'(w);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        victim_block = '0;
        for (int i = 0; i < WORDS; i++)
            victim_block[i*32 +: 32] = data[index][victim][i];
    end

    assign req      = read | write;
    assign miss     = (state == IDLE) && req && !hit;
    assign busywait = reset && ((state != IDLE) || miss);
    assign readdata = hit ? data[index][hit_way][word] : 32'h0;

    assign lru_update = (state == REFILL) || ((state == IDLE) && req && hit);
    assign lru_way    = (state == REFILL) ? v_way : hit_way;
    assign lru_index  = (state == REFILL) ? r_index : index;

    dcache_lru #(
        .SETS(SETS),
        .WAYS(WAYS)
    ) u_lru (
        .clock  (clock),
        .reset  (reset),
        .index  (lru_index),
        .way    (lru_way),
        .update (lru_update),
        .victim (lru_victim)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            if (state == IDLE && hit && write)
                data[index][hit_way][word] <= writedata;
            if (state == REFILL) begin
                tags[r_index][v_way] <= r_tag;
                for (int i = 0; i < WORDS; i++)
                    data[r_index][v_way][i] <= mem_readdata[i*32 +: 32];
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic after_refill;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
            end
            mem_read <= 1'b0;
            mem_write <= 1'b0;
            mem_address <= '0;
            mem_writedata <= '0;
            v_way <= '0;
            r_index <= '0;
            r_tag <= '0;
`ifdef DCACHE_STATS_EN
            hit_count <= '0;
            miss_count <= '0;
            after_refill <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
`ifdef DCACHE_STATS_EN
                    after_refill <= 1'b0;
                    if (miss)
                        miss_count <= miss_count + 1'b1;
                    else if (req && !after_refill)
                        hit_count <= hit_count + 1'b1;
`endif
                    if (hit && write)
                        dirty[index][hit_way] <= 1'b1;
                    if (miss) begin
                        r_index <= index;
                        r_tag <= tag;
                        v_way <= victim;
                        if (valid[index][victim] && dirty[index][victim]) begin
                            state <= WRITEBACK;
                            mem_write <= 1'b1;
                            mem_address <= {tags[index][victim], index};
                            mem_writedata <= victim_block;
                        end else begin
                            state <= FETCH;
                            mem_read <= 1'b1;
                            mem_address <= {tag, index};
                        end
                    end
                end
                WRITEBACK: begin
                    if (!mem_busywait) begin
                        state <= FETCH;
                        mem_write <= 1'b0;
                        mem_read <= 1'b1;
                        mem_address <= {r_tag, r_index};
                    end
                end
                FETCH: begin
                    if (!mem_busywait) begin
                        state <= REFILL;
                        mem_read <= 1'b0;
                    end
                end
                REFILL: begin
                    valid[r_index][v_way] <= 1'b1;
                    dirty[r_index][v_way] <= 1'b0;
                    state <= IDLE;
`ifdef DCACHE_STATS_EN
                    after_refill <= 1'b1;
`endif
                end
            endcase
        end
    end

endmodule
